f36m_mult: RTL

Sequential multiplier for GF(3^{6m}), represented as GF(3^{2m})[ρ]/(ρ³ − ρ − 1), in the pairing datapath directly downstream of `f32m_mult`. It computes the nine GF(3^{2m}) coefficient products with a single shared `f32m_mult` instance. It accumulates the products into five partial coefficients, reduces modulo ρ³ = ρ + 1, and registers the result. Its consumers are the final-exponentiation and Miller-loop stages.

---
 rtl/f36m_mult_pkg.sv | 66 ++++++
 rtl/f32m_add.sv | 23 ++
 rtl/f32m_mult.sv | 69 ++++++
 rtl/f36m_mult.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/f36m_mult_pkg.sv
// ---------------------------------------------------------------------------
// f36m_mult_pkg
// Shared widths and GF(3) / GF(3^m) arithmetic helpers for the pairing
// datapath. A GF(3) digit is two bits (00 = 0, 01 = 1, 10 = 2 = -1; 11 is
// never produced). A GF(3^m) element packs m digits, x^0 in the LSBs, and is
// reduced modulo x^5 + 2x + 1, so x^5 = x + 2.
//   WIDTH : GF(3^m)    element MSB
//   W2    : GF(3^{2m}) element MSB ({hi, lo}, element = lo + hi*sigma)
//   W6    : GF(3^{6m}) element MSB ({e2, e1, e0}, element = e0 + e1*rho + e2*rho^2)
// ---------------------------------------------------------------------------
package f36m_mult_pkg;

    localparam int M     = 5;
    localparam int WIDTH = 2 * M - 1;
    localparam int W2    = 2 * (WIDTH + 1) - 1;
    localparam int W6    = 3 * (W2 + 1) - 1;

    function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        logic [2:0] s_wrap;
        s      = {1'b0, x} + {1'b0, y};
        s_wrap = s - 3'd3;
        gf3_add = (s >= 3'd3) ? s_wrap[1:0] : s[1:0];
    endfunction

    // Negation in GF(3) swaps the encodings of 1 and 2.
    function automatic logic [1:0] gf3_neg(input logic [1:0] x);
        gf3_neg = {x[0], x[1]};
    endfunction

    function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'd0 || y == 2'd0)
            gf3_mul = 2'd0;
        else if (x == y)
            gf3_mul = 2'd1;
        else
            gf3_mul = 2'd2;
    endfunction

    function automatic logic [WIDTH:0] f3m_add(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        for (int n = 0; n < M; n++)
            f3m_add[2*n +: 2] = gf3_add(x[2*n +: 2], y[2*n +: 2]);
    endfunction

    function automatic logic [WIDTH:0] f3m_neg(input logic [WIDTH:0] x);
        for (int n = 0; n < M; n++)
            f3m_neg[2*n +: 2] = gf3_neg(x[2*n +: 2]);
    endfunction

    // Schoolbook product followed by top-down folding with x^5 = x + 2.
    function automatic logic [WIDTH:0] f3m_mul(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        logic [1:0] p [0:2*M-2];
        for (int n = 0; n <= 2 * M - 2; n++)
            p[n] = 2'd0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                p[i+j] = gf3_add(p[i+j], gf3_mul(x[2*i +: 2], y[2*j +: 2]));
        for (int n = 2 * M - 2; n >= M; n--) begin
            p[n-M+1] = gf3_add(p[n-M+1], p[n]);
            p[n-M]   = gf3_add(p[n-M], gf3_add(p[n], p[n]));
        end
        for (int n = 0; n < M; n++)
            f3m_mul[2*n +: 2] = p[n];
    endfunction

endpackage

// File: rtl/f32m_add.sv
// ---------------------------------------------------------------------------
// f32m_add
// GF(3^{2m}) adder: digit-wise GF(3) addition, no carries. Combinational.
//   a, b : addends   (W2+1 bits)
//   c    : a + b     (W2+1 bits)
// ---------------------------------------------------------------------------
module f32m_add
    import f36m_mult_pkg::*;
(
    input  logic [W2:0] a,
    input  logic [W2:0] b,
    output logic [W2:0] c
);

    // NOTE: every combinational output gets a default before any branch or
    // loop so no path can leave it unassigned and infer a latch.
    always_comb begin
        c = '0;
        for (int n = 0; n < (W2 + 1) / 2; n++)
            c[2*n +: 2] = gf3_add(a[2*n +: 2], b[2*n +: 2]);
    end

endmodule

// File: rtl/f32m_mult.sv
// ---------------------------------------------------------------------------
// f32m_mult
// Sequential GF(3^{2m}) multiplier, GF(3^m)[sigma]/(sigma^2 + 1):
//   (a0 + a1*sigma)(b0 + b1*sigma) = (a0b0 - a1b1) + (a0b1 + a1b0)*sigma
// One GF(3^m) multiplier is time-shared over four steps. A cycle with reset
// high clears the block; the four steps then run and done stays high until
// the next reset.
//   clk   : clock
//   reset : synchronous, active-high; also starts a multiplication
//   a, b  : operands, held stable until done
//   c     : product, valid while done = 1
//   done  : result valid
// ---------------------------------------------------------------------------
module f32m_mult
    import f36m_mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [W2:0] a,
    input  logic [W2:0] b,
    output logic [W2:0] c,
    output logic        done
);

    logic [1:0]     step;
    logic [WIDTH:0] t0;
    logic [WIDTH:0] t1;
    logic [WIDTH:0] mx;
    logic [WIDTH:0] my;
    logic [WIDTH:0] p;

    always_comb begin
        mx = a[WIDTH:0];
        my = b[WIDTH:0];
        case (step)
            2'd0:    begin mx = a[WIDTH:0];    my = b[WIDTH:0];    end
            2'd1:    begin mx = a[W2:WIDTH+1]; my = b[W2:WIDTH+1]; end
            2'd2:    begin mx = a[WIDTH:0];    my = b[W2:WIDTH+1]; end
            default: begin mx = a[W2:WIDTH+1]; my = b[WIDTH:0];    end
        endcase
    end

    assign p = f3m_mul(mx, my);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            step <= 2'd0;
            t0   <= '0;
            t1   <= '0;
            done <= 1'b0;
        end else if (!done) begin
            case (step)
                2'd0:    t0 <= p;
                2'd1:    t0 <= f3m_add(t0, f3m_neg(p));
                2'd2:    t1 <= p;
                default: begin
                    t1   <= f3m_add(t1, p);
                    done <= 1'b1;
                end
            endcase
            step <= step + 2'd1;
        end
    end

    assign c = {t1, t0};

endmodule

// File: rtl/f36m_mult.sv
// ---------------------------------------------------------------------------
// f36m_mult
// Sequential GF(3^{6m}) multiplier, GF(3^{2m})[rho]/(rho^3 - rho - 1).
// The nine products ai*bj are formed one at a time on a single f32m_mult and
// accumulated into d[i+j]; the five partials are then folded with
// rho^3 = rho + 1 and rho^4 = rho^2 + rho and registered.
//   clk   : clock
//   reset : synchronous, active-high; deassertion starts a multiplication
//   a, b  : operands {x2, x1, x0}, held stable from reset release to done
//   c     : product {c2, c1, c0}, registered, valid while done = 1
//   done  : result valid, held until the next reset
// ---------------------------------------------------------------------------
module f36m_mult
    import f36m_mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [W6:0] a,
    input  logic [W6:0] b,
    output logic [W6:0] c,
    output logic        done
);

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_KICK   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ACC    = 3'd3;
    localparam logic [2:0] S_REDUCE = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [3:0]  k;
    logic [1:0]  i_idx;
    logic [1:0]  j_idx;
    logic [2:0]  d_idx;
    logic [W2:0] d [0:4];
    logic [W2:0] d_cur;
    logic [W2:0] a_sel;
    logic [W2:0] b_sel;
    logic [W2:0] opa;
    logic [W2:0] opb;
    logic [W2:0] sub_c;
    logic [W2:0] acc_sum;
    logic [W2:0] r0;
    logic [W2:0] r1_part;
    logic [W2:0] r1;
    logic [W2:0] r2;
    logic        sub_reset;
    logic        sub_done;
    logic        load_ops;
    logic        acc_en;
    logic        commit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_CLEAR;
        else
            state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR:  state_next = S_KICK;
            S_KICK:   state_next = S_WAIT;
            S_WAIT:   state_next = sub_done ? S_ACC : S_WAIT;
            S_ACC:    state_next = (k == 4'd8) ? S_REDUCE : S_KICK;
            S_REDUCE: state_next = S_HOLD;
            S_HOLD:   state_next = S_HOLD;
            default:  state_next = S_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The sub-multiplier is reset for the single KICK cycle, which also clears
    // the done it still shows from the previous product.
    always_comb begin
        sub_reset = reset || (state == S_KICK);
        load_ops  = (state == S_KICK);
        acc_en    = (state == S_ACC);
        commit    = (state == S_REDUCE);
    end

    // k -> (i, j) = (k div 3, k mod 3)
    always_comb begin
        i_idx = 2'd0;
        j_idx = 2'd0;
        case (k)
            4'd1:    j_idx = 2'd1;
            4'd2:    j_idx = 2'd2;
            4'd3:    i_idx = 2'd1;
            4'd4:    begin i_idx = 2'd1; j_idx = 2'd1; end
            4'd5:    begin i_idx = 2'd1; j_idx = 2'd2; end
            4'd6:    i_idx = 2'd2;
            4'd7:    begin i_idx = 2'd2; j_idx = 2'd1; end
            4'd8:    begin i_idx = 2'd2; j_idx = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        d_idx = {1'b0, i_idx} + {1'b0, j_idx};
        d_cur = d[d_idx];
        case (i_idx)
            2'd0:    a_sel = a[W2:0];
            2'd1:    a_sel = a[2*W2+1:W2+1];
            default: a_sel = a[W6:2*W2+2];
        endcase
        case (j_idx)
            2'd0:    b_sel = b[W2:0];
            2'd1:    b_sel = b[2*W2+1:W2+1];
            default: b_sel = b[W6:2*W2+2];
        endcase
    end

    f32m_mult u_mult (
        .clk   (clk),
        .reset (sub_reset),
        .a     (opa),
        .b     (opb),
        .c     (sub_c),
        .done  (sub_done)
    );

    f32m_add u_acc (.a(d_cur), .b(sub_c), .c(acc_sum));

    // c0 = d0 + d3, c1 = d1 + d3 + d4, c2 = d2 + d4
    f32m_add u_red0  (.a(d[0]),   .b(d[3]), .c(r0));
    f32m_add u_red1a (.a(d[1]),   .b(d[3]), .c(r1_part));
    f32m_add u_red1b (.a(r1_part), .b(d[4]), .c(r1));
    f32m_add u_red2  (.a(d[2]),   .b(d[4]), .c(r2));

    // ---------------- datapath registers ----------------
    // NOTE: the partial-product file is explicitly cleared on reset because
    // accumulation reads it back; leaving it unreset would fold stale data in.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 5; n++)
                d[n] <= '0;
            k    <= 4'd0;
            opa  <= '0;
            opb  <= '0;
            c    <= '0;
            done <= 1'b0;
        end else begin
            if (load_ops) begin
                opa <= a_sel;
                opb <= b_sel;
            end
            if (acc_en) begin
                d[d_idx] <= acc_sum;
                if (k != 4'd8)
                    k <= k + 4'd1;
            end
            if (commit) begin
                c    <= {r2, r1, r0};
                done <= 1'b1;
            end
        end
    end

endmodule
